// File: rtl/ram_pkg.sv
// Shared definitions for the RAM read/write agents.
package ram_pkg;
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;
endpackage

// File: rtl/stream_fifo2.sv
// 2-entry synchronous FIFO; head entry is always in mem0 so it can drive a port directly.
module stream_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Push,
  input  logic [DATA_W-1:0] Din,
  input  logic              Pop,
  output logic              Full,
  output logic              Empty,
  output logic [DATA_W-1:0] Head
);
  logic [1:0]        cnt;
  logic [DATA_W-1:0] mem0, mem1;
  logic              pop_ok, push_ok;

  assign Full    = (cnt == 2'd2);
  assign Empty   = (cnt == 2'd0);
  assign Head    = mem0;
  assign pop_ok  = Pop & ~Empty;
  assign push_ok = Push & (~Full | pop_ok);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt  <= 2'd0;
      mem0 <= '0;
      mem1 <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (Empty) mem0 <= Din;
          else       mem1 <= Din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          mem0 <= mem1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; head advances and new word lands behind it
          if (Full) begin
            mem0 <= mem1;
            mem1 <= Din;
          end else begin
            mem0 <= Din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ram_stream_reader.sv
// Walks base/stride/count through the RAM read port and streams the words out valid/ready.
module ram_stream_reader
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W-1:0] Stride,
  input  logic [ADDR_W:0]   Count,
  output logic [ADDR_W-1:0] OutSel,
  input  logic [DATA_W-1:0] RamData,
  output logic [DATA_W-1:0] OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Done
);
  rd_state_t         state, nstate;
  logic [ADDR_W-1:0] addr, stride_q;
  logic [ADDR_W:0]   remaining;
  logic              done_q;
  logic              push, pop, full, empty;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  assign pop      = OutValid & OutReady;
  assign OutValid = ~empty;
  assign OutSel   = addr;
  assign Busy     = (state != IDLE);
  assign Done     = done_q;

  stream_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .Push  (push),
    .Din   (RamData),
    .Pop   (pop),
    .Full  (full),
    .Empty (empty),
    .Head  (OutData)
  );

  always_comb begin
    nstate = state;
    push   = 1'b0;
    case (state)
      IDLE:  if (Start) nstate = (Count == '0) ? DRAIN : READ;
      READ: begin
        // a full buffer still accepts a word on the edge it gives one up
        push = ~full | pop;
        if (push && remaining == ONE) nstate = DRAIN;
      end
      DRAIN: if (empty) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      addr      <= '0;
      stride_q  <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= nstate;
      done_q <= (state == DRAIN) && empty;
      if (state == IDLE && Start) begin
        addr      <= BaseAddr;
        stride_q  <= Stride;
        remaining <= Count;
      end else if (state == READ && push) begin
        addr      <= addr + stride_q;
        remaining <= remaining - ONE;
      end
    end
  end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a RAM model holding mem[a] = a*256.
module tb_ram_stream_reader;
  logic        Clk = 1'b0, Reset = 1'b0, Start = 1'b0, OutReady = 1'b0;
  logic [7:0]  BaseAddr = '0, Stride = '0, OutSel;
  logic [8:0]  Count = '0;
  logic [31:0] RamData, OutData;
  logic        OutValid, Busy, Done;

  logic [31:0] mem [256];
  assign RamData = mem[OutSel];

  always #5 Clk = ~Clk;

  ram_stream_reader dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .Stride(Stride),
    .Count(Count), .OutSel(OutSel), .RamData(RamData), .OutData(OutData),
    .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy), .Done(Done)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model state: expected words, accepted words, burst bookkeeping
  logic [31:0] exp_q[$], got[$];
  int  done_cnt, done_cyc, first_vld_cyc, last_acc_cyc, vld_seen, acc;
  bit  mon_en = 0, track = 0, have_prev, stall_prev, pop_prev;
  logic [7:0]  tbase;
  logic [31:0] data_prev;
  int  tcount, idx, occ, idx_prev, acc_prev, exp_idx;

  always @(negedge Clk) begin
    if (!Reset && mon_en) begin
      if (Done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_with_done", 32'(Busy), 32'd0);
      end
      if (OutValid) begin
        vld_seen++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      if (stall_prev) begin
        check("stall_valid", 32'(OutValid), 32'd1);
        check("stall_data", OutData, data_prev);
      end
      if (track) begin
        // stride-1 bursts: address index = words fetched; occupancy = fetched - accepted
        idx = int'(8'(OutSel - tbase));
        occ = idx - acc;
        check("valid_vs_occupancy", 32'(OutValid), 32'(occ > 0));
        if (have_prev) begin
          exp_idx = idx_prev + ((idx_prev < tcount && (idx_prev - acc_prev < 2 || pop_prev)) ? 1 : 0);
          check("outsel_index", 32'(idx), 32'(exp_idx));
        end
        have_prev = 1;
        idx_prev  = idx;
        acc_prev  = acc;
        pop_prev  = OutValid && OutReady;
      end
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_word: got %0h expected no word", OutData);
        end else begin
          check("stream_data", OutData, exp_q.pop_front());
        end
        got.push_back(OutData);
        acc++;
        last_acc_cyc = cyc;
      end
      stall_prev = OutValid && !OutReady;
      data_prev  = OutData;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outsel"}, 32'(OutSel), 32'd0);
    check({tag, "_outdata"}, OutData, 32'd0);
    check({tag, "_outvalid"}, 32'(OutValid), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd0);
  endtask

  // mode 0: OutReady held high; mode 1: OutReady high every third cycle
  task automatic burst(input logic [7:0] b, input logic [7:0] s, input int n,
                       input int mode, input bit restart, input int abort_at);
    int k, t;
    track = 0; exp_q.delete(); got.delete();
    done_cnt = 0; first_vld_cyc = -1; vld_seen = 0; acc = 0;
    have_prev = 0; stall_prev = 0; tbase = b; tcount = n;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[8'(b + i * s)]);
    @(posedge Clk); #1;
    Start = 1; BaseAddr = b; Stride = s; Count = 9'(n); OutReady = (mode == 0);
    @(posedge Clk); #1;
    k = cyc;
    track = (s == 8'd1) && (n < 256);
    if (restart) begin BaseAddr = 8'h40; Count = 9'd3; end
    else Start = 0;
    check("start_outsel", 32'(OutSel), 32'(b));
    check("start_busy", 32'(Busy), 32'd1);
    t = 0;
    while (done_cnt == 0 && t < 600) begin
      @(posedge Clk); #1;
      Start = 0;
      t++;
      if (abort_at > 0 && t == abort_at) break;
      OutReady = (mode == 0) ? 1'b1 : (t % 3 == 0);
    end
    if (abort_at > 0) begin
      check("abort_no_done_yet", 32'(done_cnt), 32'd0);
      check("abort_busy_before", 32'(Busy), 32'd1);
      Reset = 1; track = 0; stall_prev = 0;
      #1;
      check_reset_outputs("abort");
      @(posedge Clk); #1;
      check_reset_outputs("abort_held");
      Reset = 0;
      repeat (2) @(posedge Clk);
      #1;
      check("abort_no_done", 32'(done_cnt), 32'd0);
      return;
    end
    if (done_cnt == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no Done expected Done within 600 cycles");
    end
    repeat (3) @(posedge Clk);
    #1;
    track = 0;
    check("done_once", 32'(done_cnt), 32'd1);
    check("idle_after", 32'(Busy), 32'd0);
    check("word_count", 32'(got.size()), 32'(n));
    check("model_drained", 32'(exp_q.size()), 32'd0);
    if (n == 0) begin
      check("cnt0_done_cyc", 32'(done_cyc), 32'(k + 1));
      check("cnt0_no_valid", 32'(vld_seen), 32'd0);
    end else if (mode == 0) begin
      check("first_valid_cyc", 32'(first_vld_cyc), 32'(k + 1));
      check("last_accept_cyc", 32'(last_acc_cyc), 32'(k + n));
      check("done_cyc", 32'(done_cyc), 32'(k + n + 2));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) << 8;
    #2 Reset = 1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge Clk);
    #1 Reset = 0;
    mon_en = 1;

    burst(8'h00, 8'd8, 4, 0, 0, 0);
    check("t1_w0", got[0], 32'h0000);
    check("t1_w1", got[1], 32'h0800);
    check("t1_w2", got[2], 32'h1000);
    check("t1_w3", got[3], 32'h1800);

    burst(8'hF0, 8'd8, 4, 0, 0, 0);
    check("wrap_w0", got[0], 32'hF000);
    check("wrap_w1", got[1], 32'hF800);
    check("wrap_w2", got[2], 32'h0000);
    check("wrap_w3", got[3], 32'h0800);

    burst(8'h10, 8'd1, 6, 1, 0, 0);
    check("bp_w0", got[0], 32'h1000);
    check("bp_w5", got[5], 32'h1500);

    burst(8'h20, 8'd1, 0, 0, 1, 0);
    repeat (4) @(posedge Clk);
    #1;
    check("restart_ignored_busy", 32'(Busy), 32'd0);
    check("restart_ignored_valid", 32'(vld_seen), 32'd0);

    burst(8'h33, 8'd0, 3, 0, 0, 0);
    check("stride0_w2", got[2], 32'h3300);

    burst(8'h00, 8'd1, 256, 0, 0, 0);
    check("full_w0", got[0], 32'h0000);
    check("full_w255", got[255], 32'hFF00);

    burst(8'h00, 8'd1, 256, 0, 0, 100);

    burst(8'h05, 8'd1, 5, 1, 0, 0);
    check("post_abort_w0", got[0], 32'h0500);
    check("post_abort_w4", got[4], 32'h0900);

    burst(8'hFE, 8'd3, 3, 0, 0, 0);
    check("post_abort_s3_w2", got[2], 32'h0400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side sequencer for the 256-word, 32-bit `RAM` block. It owns the RAM read port (`OutSel`/`Out`). On `Start` it walks a programmable address sequence (base, stride, count) and returns the words as a valid/ready stream through a 2-entry output buffer. It is the counterpart to the write-side agent that fills the RAM through `InSel`/`In`, and lets downstream logic consume RAM contents without managing addresses.

## Interface
- `ADDR_W`, 8: RAM address width; the address space wraps modulo 2^ADDR_W.
- `DATA_W`, 32: RAM word width.
- `Clk`  in  1: single clock, rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `Start`  in  1: starts a burst; sampled only in IDLE.
- `BaseAddr`  in  ADDR_W: first read address; captured with `Start`.
- `Stride`  in  ADDR_W: address increment per word; captured with `Start`.
- `Count`  in  ADDR_W+1: words to read, 0..256; captured with `Start`.
- `OutSel`  out  ADDR_W: RAM read address.
- `RamData`  in  DATA_W: RAM read data, wired to RAM `Out`.
- `OutData`  out  DATA_W: head word of the stream.
- `OutValid`  out  1: `OutData` is valid.
- `OutReady`  in  1: the consumer accepts the word when `OutValid & OutReady`.
- `Busy`  out  1: high in every state except IDLE.
- `Done`  out  1: one-cycle pulse when a burst completes.

## Operation
- RAM read is asynchronous. `RamData` reflects `OutSel` in the same cycle. The block samples `RamData` on the next `Clk` edge.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: if `Start`, capture `BaseAddr`/`Stride`/`Count`, load `OutSel <= BaseAddr` and `Remaining <= Count`.
    - If `Count == 0`, go to DRAIN with an empty buffer.
    - Otherwise go to READ.
  - READ: a push occurs each edge where the buffer is not full, or is full but popping this edge. On a push:
    - buffer `RamData`;
    - `OutSel <= OutSel + Stride`, modulo 2^ADDR_W;
    - `Remaining <= Remaining - 1`.
    - Go to DRAIN on the push that brings `Remaining` to 0.
  - DRAIN: no RAM reads; `OutSel` holds. When the buffer is empty, pulse `Done` for one cycle and go to IDLE.
- Output buffer is 2-entry FIFO order. `OutData` is the oldest entry.
  - Push and pop in the same edge are both honoured.
  - There is no overflow (push is gated) and no underflow (pop is gated by `OutValid`).
- `Start` while `Busy` is ignored. It is not queued.
- `Stride == 0` rereads the same address `Count` times.
- Address wrap is silent: 0xF8 + 8 gives 0x00.
- Reset at any time clears all state immediately and aborts any burst in progress with no `Done`.
- Reset values: state IDLE, `OutSel`=0, `OutData`=0, `OutValid`=0, `Busy`=0, `Done`=0, buffer empty.

## Timing
- `Start` sampled at edge k gives `OutSel = BaseAddr` after k and `OutValid = 1` after k+1.
- With `OutReady` held high: one word per cycle. Word i is on `OutData` during the cycle after edge k+1+i.
- The last word of an N-word burst (N ≥ 1) is accepted at edge k+N+1. The `Done` pulse occurs in the cycle after edge k+N+2. `Busy` drops with it.
- `Count == 0`: `Done` is high in the cycle after edge k+1. `OutValid` never asserts.
- Backpressure: while `OutReady` is low the buffer fills with 2 words and then reads stall. `OutSel` holds at the next unread address. Reads resume on the edge where a pop occurs.
- `OutData` and `OutValid` stay stable while `OutValid & ~OutReady`.

## Structure
- Shared package `ram_pkg`:
  - `RAM_ADDR_W`=8, `RAM_DATA_W`=32;
  - state enum `rd_state_t` {IDLE, READ, DRAIN}.
- Sub-module `stream_fifo2`: 2-entry synchronous FIFO. Ports `Clk`, `Reset`, push/data-in, pop, `Full`, `Empty`, head data. Reused by other stream blocks.
- Top level holds the FSM, the address register and the `Remaining` counter.

## Test plan
RAM is preloaded with mem[a] = a*256.
- Base=0x00, Stride=8, Count=4, `OutReady`=1 -> stream 0x0, 0x800, 0x1000, 0x1800 on consecutive cycles. `Done` pulses exactly once, 2 cycles after the last beat.
- Base=0xF0, Stride=8, Count=4 -> stream 0xF000, 0xF800, 0x0000, 0x0800 (wrap).
- Base=0x10, Stride=1, Count=6, `OutReady` toggling 1,0,0,1,... ->
  - words 0x1000..0x1500 arrive in order with none lost or duplicated;
  - `OutSel` stalls while the buffer is full;
  - `OutData` is stable during stalls.
- Count=0 -> `Done` in the cycle after the cycle following `Start`; `OutValid` stays 0. A second `Start` while `Busy` is ignored.
- Count=256, Stride=1 -> all 256 words, 0x0..0xFF00. Reset asserted mid-burst -> all outputs return to reset values within the same cycle, with no `Done`. A new burst afterwards runs correctly.
